// File: rtl/prbs_checker_pkg.sv
// Shared types, counter widths and the LFSR advance function for the PRBS
// stream checker. The optional first-error capture is enabled by defining
// PRBS_CHECKER_FIRST_ERR_EN; see prbs_stream_checker.sv.
package prbs_checker_pkg;

    // Lock state of the checker.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Output counter widths.
    localparam int WORD_CNT_W     = 48;
    localparam int ERR_WORD_CNT_W = 32;
    localparam int LOL_CNT_W      = 16;

    // Match/bad run counters; LOCK_COUNT and UNLOCK_COUNT are limited to 1..255.
    localparam int RUN_CNT_W = 8;

    // Widest LFSR the shared advance function handles.
    localparam int LFSR_MAX_W = 64;

    // Advance a width-bit Fibonacci LFSR by width steps:
    // s = {s[width-2:0], ^(s & poly)}. Bits at and above width are zero.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_advance(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] s;
        logic                  fb;
        mask = '0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        s = state & mask;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i < width) begin
                fb = ^(s & poly & mask);
                s  = ((s << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/prbs_stream_checker_popcount.sv
// Combinational population count used by the error-bit accumulator.
module bit_popcount #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    // Sum of all set bits in the input word.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/prbs_stream_checker.sv
// PRBS stream checker: locks onto an AXI-Stream PRBS sequence and measures
// injected errors (word count, errored words, errored bits, loss of lock,
// last error pattern).
// Optional macro PRBS_CHECKER_FIRST_ERR_EN adds first_err_valid,
// first_err_word and first_err_bit (first errored locked word since clear).
//
// Pipeline: word accepted in cycle N -> diff, FSM, run counters at N+1 ->
// statistics counters and last_error_bits at N+2.
module prbs_stream_checker
    import prbs_checker_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(32'h48000000),
    parameter int               LOCK_COUNT   = 16,
    parameter int               UNLOCK_COUNT = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      clear,
    // Stream handshake: a word transfers on every rising clk edge where
    // S_AXIS_TVALID=1. S_AXIS_TREADY is constant 1, so TVALID alone qualifies
    // a transfer and TDATA is ignored whenever TVALID=0.
    input  logic [WIDTH-1:0]          S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    output logic                      locked,
    output logic [WORD_CNT_W-1:0]     word_count,
    output logic [ERR_WORD_CNT_W-1:0] error_word_count,
    output logic [WORD_CNT_W-1:0]     error_bit_count,
    output logic [LOL_CNT_W-1:0]      loss_of_lock_count,
    output logic [WIDTH-1:0]          last_error_bits,
`ifdef PRBS_CHECKER_FIRST_ERR_EN
    output logic                      first_err_valid,
    output logic [WORD_CNT_W-1:0]     first_err_word,
    output logic [$clog2(WIDTH)-1:0]  first_err_bit,
`endif
    output state_t                    fsm_state
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam logic [RUN_CNT_W-1:0] LOCK_TARGET   = RUN_CNT_W'(LOCK_COUNT);
    localparam logic [RUN_CNT_W-1:0] UNLOCK_TARGET = RUN_CNT_W'(UNLOCK_COUNT);

    state_t               state;
    logic [WIDTH-1:0]     expected;
    logic [RUN_CNT_W-1:0] match_run;
    logic [RUN_CNT_W-1:0] bad_run;

    logic [WIDTH-1:0]     seed;
    logic [WIDTH-1:0]     expected_adv;
    logic [WIDTH-1:0]     live_diff;
    logic                 live_err;

    logic [WIDTH-1:0]     diff_q;
    logic                 s1_valid;
    logic                 diff_nz;

    logic [POP_W-1:0]          pop_count;
    logic [WORD_CNT_W:0]       eb_sum;
    logic [WORD_CNT_W-1:0]     eb_next;
    logic [WORD_CNT_W-1:0]     wc_next;
    logic [ERR_WORD_CNT_W-1:0] ew_next;
    logic [LOL_CNT_W-1:0]      lol_next;

    assign S_AXIS_TREADY = 1'b1;
    assign fsm_state     = state;

    // In SEARCH the prediction is always reseeded from the received word;
    // once LOCKED it free-runs from its own state so errors do not propagate.
    assign seed         = (state == LOCKED) ? expected : S_AXIS_TDATA;
    assign expected_adv = WIDTH'(lfsr_advance(LFSR_MAX_W'(seed), LFSR_MAX_W'(POLY), WIDTH));
    assign live_diff    = S_AXIS_TDATA ^ expected;
    assign live_err     = (live_diff != '0);

    assign lol_next = (&loss_of_lock_count) ? loss_of_lock_count
                                            : loss_of_lock_count + LOL_CNT_W'(1);

    // Lock FSM, LFSR prediction register, run counters and loss-of-lock count.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state              <= SEARCH;
            locked             <= 1'b0;
            expected           <= '0;
            match_run          <= '0;
            bad_run            <= '0;
            loss_of_lock_count <= '0;
        end else begin
            if (clear) begin
                loss_of_lock_count <= '0;
            end
            if (S_AXIS_TVALID) begin
                expected <= expected_adv;
                case (state)
                    SEARCH: begin
                        if (!live_err) begin
                            if ((match_run + RUN_CNT_W'(1)) == LOCK_TARGET) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_run <= '0;
                            end else begin
                                match_run <= match_run + RUN_CNT_W'(1);
                            end
                        end else begin
                            match_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (live_err) begin
                            if ((bad_run + RUN_CNT_W'(1)) == UNLOCK_TARGET) begin
                                state   <= SEARCH;
                                locked  <= 1'b0;
                                bad_run <= '0;
                                if (!clear) begin
                                    loss_of_lock_count <= lol_next;
                                end
                            end else begin
                                bad_run <= bad_run + RUN_CNT_W'(1);
                            end
                        end else begin
                            bad_run <= '0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stage 1: register the error pattern of each accepted word; only words
    // received while LOCKED (and not cancelled by clear) reach the counters.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            diff_q   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= S_AXIS_TVALID && (state == LOCKED) && !clear;
            if (S_AXIS_TVALID) begin
                diff_q <= live_diff;
            end
        end
    end

    bit_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (POP_W)
    ) u_popcount (
        .bits  (diff_q),
        .count (pop_count)
    );

    assign diff_nz = (diff_q != '0);
    assign eb_sum  = {1'b0, error_bit_count} + (WORD_CNT_W+1)'(pop_count);
    assign eb_next = eb_sum[WORD_CNT_W] ? {WORD_CNT_W{1'b1}} : eb_sum[WORD_CNT_W-1:0];
    assign wc_next = (&word_count) ? word_count : word_count + WORD_CNT_W'(1);
    assign ew_next = (&error_word_count) ? error_word_count
                                         : error_word_count + ERR_WORD_CNT_W'(1);

`ifdef PRBS_CHECKER_FIRST_ERR_EN
    localparam int IDX_W = $clog2(WIDTH);
    logic [IDX_W-1:0] low_idx;

    // Lowest set bit index of the registered error pattern.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // First errored locked word since clear/reset, captured with the counters.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            first_err_valid <= 1'b0;
            first_err_word  <= '0;
            first_err_bit   <= '0;
        end else if (s1_valid && diff_nz && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_word  <= wc_next;
            first_err_bit   <= low_idx;
        end
    end
`endif

    // Stage 2: saturating statistics counters and last error pattern.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            word_count       <= '0;
            error_word_count <= '0;
            error_bit_count  <= '0;
            last_error_bits  <= '0;
        end else if (s1_valid) begin
            word_count <= wc_next;
            if (diff_nz) begin
                error_word_count <= ew_next;
                error_bit_count  <= eb_next;
                last_error_bits  <= diff_q;
            end
        end
    end

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Directed bench for prbs_stream_checker: table of stream segments with
// hand-computed cumulative counter values, plus hand-written saturation and
// mid-stream reset sequences.
module tb_prbs_stream_checker;
  import prbs_checker_pkg::*;

  localparam int          WIDTH = 32;
  localparam logic [31:0] POLY  = 32'h48000000;

  logic        clk;
  logic        aresetn;
  logic        clear;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        locked;
  logic [47:0] word_count;
  logic [31:0] error_word_count;
  logic [47:0] error_bit_count;
  logic [15:0] loss_of_lock_count;
  logic [31:0] last_error_bits;
  state_t      fsm_state;

  prbs_stream_checker #(
    .WIDTH        (WIDTH),
    .POLY         (POLY),
    .LOCK_COUNT   (16),
    .UNLOCK_COUNT (8)
  ) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .clear              (clear),
    .S_AXIS_TDATA       (tdata),
    .S_AXIS_TVALID      (tvalid),
    .S_AXIS_TREADY      (tready),
    .locked             (locked),
    .word_count         (word_count),
    .error_word_count   (error_word_count),
    .error_bit_count    (error_bit_count),
    .loss_of_lock_count (loss_of_lock_count),
    .last_error_bits    (last_error_bits),
    .fsm_state          (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] cur;

  typedef struct {
    string       name;
    int          n_words;
    int          err_start;
    int          err_len;
    logic [31:0] err_mask;
    logic        err_shift;
    int          clear_at;
    int          edge_at;
    logic        edge_val;
    logic        exp_locked;
    logic [47:0] exp_wc;
    logic [31:0] exp_ew;
    logic [47:0] exp_eb;
    logic [15:0] exp_lol;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    repeat (32) t = {t[30:0], ^(t & POLY)};
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_word(input logic [31:0] d);
    tvalid = 1'b1;
    tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_prbs(input logic [31:0] m);
    send_word(cur ^ m);
    cur = prbs_next(cur);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic l, input logic [47:0] wc,
                           input logic [31:0] ew, input logic [47:0] eb,
                           input logic [15:0] lol, input logic [31:0] last);
    chk({name, "_locked"}, 64'(locked), 64'(l));
    chk({name, "_word_count"}, 64'(word_count), 64'(wc));
    chk({name, "_error_word_count"}, 64'(error_word_count), 64'(ew));
    chk({name, "_error_bit_count"}, 64'(error_bit_count), 64'(eb));
    chk({name, "_loss_of_lock"}, 64'(loss_of_lock_count), 64'(lol));
    chk({name, "_last_error_bits"}, 64'(last_error_bits), 64'(last));
  endtask

  initial begin
    logic [31:0] m;
    //          name         n     es   el  mask           sh    clr edge ev    L     wc         ew            eb         lol     last
    vecs[0]  = '{"lock",      17,   0,   0, 32'h0,         1'b0, -1, 16, 1'b1, 1'b1, 48'd0,    32'd0,  48'd0,  16'd0, 32'h0};
    vecs[1]  = '{"clean1000", 1000, 0,   0, 32'h0,         1'b0, -1, -1, 1'b0, 1'b1, 48'd1000, 32'd0,  48'd0,  16'd0, 32'h0};
    vecs[2]  = '{"single_err",150,  100, 1, 32'h00000101,  1'b0, -1, -1, 1'b0, 1'b1, 48'd1150, 32'd1,  48'd2,  16'd0, 32'h00000101};
    vecs[3]  = '{"unlock",    8,    0,   8, 32'h1,         1'b1, -1, 7,  1'b0, 1'b0, 48'd1158, 32'd9,  48'd10, 16'd1, 32'h80};
    vecs[4]  = '{"relock",    16,   0,   0, 32'h0,         1'b0, -1, 15, 1'b1, 1'b1, 48'd1158, 32'd9,  48'd10, 16'd1, 32'h80};
    vecs[5]  = '{"clean20",   20,   0,   0, 32'h0,         1'b0, -1, -1, 1'b0, 1'b1, 48'd1178, 32'd9,  48'd10, 16'd1, 32'h80};
    vecs[6]  = '{"clear_err", 1,    0,   1, 32'h000000F0,  1'b0, 0,  -1, 1'b0, 1'b1, 48'd0,    32'd0,  48'd0,  16'd0, 32'h0};
    vecs[7]  = '{"msb_err",   5,    2,   1, 32'h80000000,  1'b0, -1, -1, 1'b0, 1'b1, 48'd5,    32'd1,  48'd1,  16'd0, 32'h80000000};
    vecs[8]  = '{"all_bits",  3,    1,   1, 32'hFFFFFFFF,  1'b0, -1, -1, 1'b0, 1'b1, 48'd8,    32'd2,  48'd33, 16'd0, 32'hFFFFFFFF};
    vecs[9]  = '{"run7",      7,    0,   7, 32'h1,         1'b1, -1, -1, 1'b0, 1'b1, 48'd15,   32'd9,  48'd40, 16'd0, 32'h40};
    vecs[10] = '{"break_run", 8,    1,   7, 32'h1,         1'b1, -1, -1, 1'b0, 1'b1, 48'd23,   32'd16, 48'd47, 16'd0, 32'h40};

    aresetn = 1'b0;
    clear   = 1'b0;
    tvalid  = 1'b0;
    tdata   = '0;
    cur     = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;

    // reset state
    check_all("reset", 1'b0, 48'd0, 32'd0, 48'd0, 16'd0, 32'h0);
    chk("reset_tready", 64'(tready), 64'd1);
    chk("reset_state", 64'(fsm_state), 64'(SEARCH));

    // table-driven segments, expectations cumulative
    for (int v = 0; v < 11; v++) begin
      for (int w = 0; w < vecs[v].n_words; w++) begin
        m = 32'h0;
        if (w >= vecs[v].err_start && w < vecs[v].err_start + vecs[v].err_len)
          m = vecs[v].err_shift ? (vecs[v].err_mask << (w - vecs[v].err_start)) : vecs[v].err_mask;
        clear = (w == vecs[v].clear_at);
        send_prbs(m);
        clear = 1'b0;
        if (w == vecs[v].edge_at - 1)
          chk({vecs[v].name, "_locked_before_edge"}, 64'(locked), 64'(!vecs[v].edge_val));
        if (w == vecs[v].edge_at)
          chk({vecs[v].name, "_locked_at_edge"}, 64'(locked), 64'(vecs[v].edge_val));
      end
      idle(2);
      check_all(vecs[v].name, vecs[v].exp_locked, vecs[v].exp_wc, vecs[v].exp_ew,
                vecs[v].exp_eb, vecs[v].exp_lol, vecs[v].exp_last);
    end

    // saturation of error_word_count
    force dut.error_word_count = 32'hFFFFFFFE;
    idle(1);
    release dut.error_word_count;
    send_prbs(32'h0);
    repeat (3) send_prbs(32'h1);
    idle(2);
    chk("sat_error_word_count", 64'(error_word_count), 64'hFFFFFFFF);
    chk("sat_error_bit_count", 64'(error_bit_count), 64'd50);
    chk("sat_word_count", 64'(word_count), 64'd27);
    chk("sat_locked", 64'(locked), 64'd1);

    // reset mid-stream while locked, with an errored word in flight
    repeat (5) send_prbs(32'h0);
    send_prbs(32'h3);
    tvalid  = 1'b0;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    check_all("midreset", 1'b0, 48'd0, 32'd0, 48'd0, 16'd0, 32'h0);
    chk("midreset_state", 64'(fsm_state), 64'(SEARCH));
    for (int w = 0; w < 17; w++) begin
      send_prbs(32'h0);
      if (w == 15) chk("midreset_relock_w15", 64'(locked), 64'd0);
      if (w == 16) chk("midreset_relock_w16", 64'(locked), 64'd1);
    end
    idle(2);
    chk("midreset_word_count", 64'(word_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
